fifo_rr_sched: RTL and testbench

- Round-robin read scheduler that drains N_SRC independent synchronous FIFOs into one valid/ready output stream, e.g. several request queues feeding the single hash-table lookup pipeline.
- Sequences each FIFO's rd_en so it matches the FIFO read timing: the output word is registered from the head slot, and empty/full flags are decoded from the occupancy counter.
- Supports bounded bursts per source, and tags every output word with its source index.

---
 rtl/rr_sched_pkg.sv | 15 +
 rtl/rr_pick.sv | 32 +++
 rtl/fifo_rr_sched.sv | 127 ++++++++++++
 tb/tb_fifo_rr_sched.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_sched_pkg.sv
// Shared types and helpers for the round-robin FIFO read scheduler.
package rr_sched_pkg;

   typedef enum logic [1:0] {
      S_ARB = 2'd0,
      S_POP = 2'd1,
      S_OUT = 2'd2
   } state_e;

   // Width of a source index; never narrower than one bit.
   function automatic int unsigned src_w(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to 0.
module rr_pick #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         found,
   output logic [W-1:0] idx
);

   logic [N-1:0] hi_req;

   always_comb begin
      hi_req = '0;
      for (int i = 0; i < int'(N); i++) begin
         hi_req[i] = req[i] && (i >= 32'(ptr));
      end
      found = |req;
      idx   = '0;
      // Lowest set bit overall is the wrap-around fallback.
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req[i]) idx = W'(i);
      end
      if (|hi_req) begin
         for (int i = int'(N) - 1; i >= 0; i--) begin
            if (hi_req[i]) idx = W'(i);
         end
      end
   end

endmodule

// File: rtl/fifo_rr_sched.sv
// Drains N_SRC synchronous FIFOs into one valid/ready stream with bounded round-robin bursts.
module fifo_rr_sched
   import rr_sched_pkg::*;
#(
   parameter int unsigned N_SRC     = 4,
   parameter int unsigned D_WIDTH   = 8,
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned SRC_W     = src_w(N_SRC)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       arb_en,
   input  logic [N_SRC-1:0]           fifo_empty,
   input  logic [N_SRC*D_WIDTH-1:0]   fifo_dout,
   output logic [N_SRC-1:0]           fifo_rd_en,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [D_WIDTH-1:0]         m_data,
   output logic [SRC_W-1:0]           m_src,
   output logic                       busy
);

   localparam int unsigned BC_W = $clog2(MAX_BURST + 1);

   state_e             state_q, state_d;
   logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
   // Doubles as the current grant: it only changes when a new grant is made.
   logic [SRC_W-1:0]   last_q, last_d;
   logic [BC_W-1:0]    burst_cnt_q, burst_cnt_d;
   logic               m_valid_q, m_valid_d;
   logic [D_WIDTH-1:0] m_data_q, m_data_d;
   logic [SRC_W-1:0]   m_src_q, m_src_d;

   logic               pick_found;
   logic [SRC_W-1:0]   pick_idx;
   logic               last_empty;
   logic [D_WIDTH-1:0] last_head;

   rr_pick #(
      .N (N_SRC),
      .W (SRC_W)
   ) u_pick (
      .req   (~fifo_empty),
      .ptr   (rr_ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      last_empty = 1'b1;
      last_head  = '0;
      fifo_rd_en = '0;
      for (int i = 0; i < int'(N_SRC); i++) begin
         if (last_q == SRC_W'(i)) begin
            last_empty    = fifo_empty[i];
            last_head     = fifo_dout[i*D_WIDTH +: D_WIDTH];
            fifo_rd_en[i] = (state_q == S_POP);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      last_d      = last_q;
      burst_cnt_d = burst_cnt_q;
      m_valid_d   = m_valid_q;
      m_data_d    = m_data_q;
      m_src_d     = m_src_q;
      unique case (state_q)
         S_ARB: begin
            if (arb_en && pick_found) begin
               state_d = S_POP;
               if (!(burst_cnt_q < BC_W'(MAX_BURST) && burst_cnt_q != '0 && !last_empty)) begin
                  last_d      = pick_idx;
                  burst_cnt_d = '0;
               end
            end
         end
         S_POP: begin
            m_data_d    = last_head;
            m_src_d     = last_q;
            m_valid_d   = 1'b1;
            burst_cnt_d = burst_cnt_q + 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               state_d   = S_ARB;
               // Empty here means the pop just taken was the source's last word.
               if (burst_cnt_q == BC_W'(MAX_BURST) || last_empty) begin
                  rr_ptr_d    = (last_q == SRC_W'(N_SRC - 1)) ? '0 : last_q + 1'b1;
                  burst_cnt_d = '0;
               end
            end
         end
         default: state_d = S_ARB;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_ARB;
         rr_ptr_q    <= '0;
         last_q      <= '0;
         burst_cnt_q <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         m_src_q     <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         last_q      <= last_d;
         burst_cnt_q <= burst_cnt_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         m_src_q     <= m_src_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_src   = m_src_q;
   assign busy    = (state_q != S_ARB);

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Bench for fifo_rr_sched: queue-based FIFO models, per-source scoreboard and directed scenarios.
module tb_fifo_rr_sched;

   localparam int N_SRC   = 4;
   localparam int D_WIDTH = 8;
   localparam int SRC_W   = 2;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b1;
   logic                     arb_en = 1'b0;
   logic                     m_ready = 1'b0;
   logic [N_SRC-1:0]         fifo_empty = '1;
   logic [N_SRC*D_WIDTH-1:0] fifo_dout = '0;
   logic [N_SRC-1:0]         fifo_rd_en;
   logic                     m_valid;
   logic [D_WIDTH-1:0]       m_data;
   logic [SRC_W-1:0]         m_src;
   logic                     busy;

   fifo_rr_sched #(
      .N_SRC     (N_SRC),
      .D_WIDTH   (D_WIDTH),
      .MAX_BURST (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .arb_en     (arb_en),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_src      (m_src),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   logic [D_WIDTH-1:0] fq[N_SRC][$];
   logic [D_WIDTH-1:0] exp_q[N_SRC][$];
   int                 src_log[$];
   logic [D_WIDTH-1:0] dat_log[$];
   int                 pop_cyc[$];
   int                 cycle = 0;
   int                 checks = 0;
   int                 errors = 0;
   int                 delivered = 0;
   int                 pushed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int s, input logic [D_WIDTH-1:0] d);
      fq[s].push_back(d);
      exp_q[s].push_back(d);
      pushed++;
   endtask

   task automatic clear_all();
      for (int i = 0; i < N_SRC; i++) begin
         fq[i].delete();
         exp_q[i].delete();
      end
      src_log.delete();
      dat_log.delete();
      pop_cyc.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_all();
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_valid(input string name, input int max);
      int n = 0;
      while (!m_valid && n < max) begin
         tick();
         n++;
      end
      checks++;
      if (!m_valid) begin
         errors++;
         $display("FAIL %s: m_valid not seen within %0d cycles", name, max);
      end
   endtask

   task automatic wait_log(input string name, input int cnt, input int max);
      int n = 0;
      while (src_log.size() < cnt && n < max) begin
         tick();
         n++;
      end
      checks++;
      if (src_log.size() < cnt) begin
         errors++;
         $display("FAIL %s: %0d words delivered, want %0d", name, src_log.size(), cnt);
      end
   endtask

   // FIFO models: pop on rd_en, flags and head refresh on the clock edge.
   always @(posedge clk) begin
      cycle++;
      for (int i = 0; i < N_SRC; i++) begin
         if (fifo_rd_en[i] && fq[i].size() > 0) void'(fq[i].pop_front());
      end
      for (int i = 0; i < N_SRC; i++) begin
         fifo_empty[i] <= (fq[i].size() == 0);
         fifo_dout[i*D_WIDTH +: D_WIDTH] <= (fq[i].size() > 0) ? fq[i][0] : '0;
      end
   end

   logic               prev_stall = 1'b0;
   logic [D_WIDTH-1:0] prev_data;
   logic [SRC_W-1:0]   prev_src;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (fifo_rd_en != '0) begin
            pop_cyc.push_back(cycle);
            chk("rd_en_onehot", 32'($onehot(fifo_rd_en)), 1);
            chk("rd_en_on_empty", 32'(fifo_rd_en & fifo_empty), 0);
            chk("rd_en_phase", {30'd0, busy, m_valid}, 2);
         end
         if (prev_stall) begin
            chk("stall_valid", 32'(m_valid), 1);
            chk("stall_data", 32'(m_data), 32'(prev_data));
            chk("stall_src", 32'(m_src), 32'(prev_src));
         end
         if (m_valid && m_ready) begin
            src_log.push_back(int'(m_src));
            dat_log.push_back(m_data);
            delivered++;
            checks++;
            if (exp_q[m_src].size() == 0) begin
               errors++;
               $display("FAIL sb_extra: src %0d data %0h, no word expected", m_src, m_data);
            end else begin
               logic [D_WIDTH-1:0] e;
               e = exp_q[m_src].pop_front();
               if (m_data !== e) begin
                  errors++;
                  $display("FAIL sb_data: src %0d got %0h, want %0h", m_src, m_data, e);
               end
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_src   = m_src;
      end
   end

   initial begin
      int c0;
      int c1;
      int n0;
      int exp_order[24] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3,
                            0, 0, 1, 1, 2, 2, 3, 3};

      // Reset values
      #1 rst_n = 1'b0;
      #1;
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rd_en", 32'(fifo_rd_en), 0);
      chk("rst_m_data", 32'(m_data), 0);
      chk("rst_m_src", 32'(m_src), 0);
      do_reset();

      // Single source, three words
      arb_en = 1'b1;
      m_ready = 1'b1;
      push(2, 8'h11);
      push(2, 8'h22);
      push(2, 8'h33);
      c0 = -1;
      for (int i = 0; i < 10 && c0 < 0; i++) begin
         tick();
         if (!fifo_empty[2]) c0 = cycle;
      end
      wait_valid("t1_first_valid", 10);
      c1 = cycle;
      chk("t1_latency", 32'(c1 - c0), 2);
      wait_log("t1_words", 3, 50);
      repeat (10) tick();
      chk("t1_count", 32'(src_log.size()), 3);
      chk("t1_d0", 32'(dat_log[0]), 32'h11);
      chk("t1_d1", 32'(dat_log[1]), 32'h22);
      chk("t1_d2", 32'(dat_log[2]), 32'h33);
      for (int i = 0; i < 3; i++) chk("t1_src", 32'(src_log[i]), 2);
      chk("t1_pops", 32'(pop_cyc.size()), 3);
      chk("t1_gap0", 32'(pop_cyc[1] - pop_cyc[0]), 3);
      chk("t1_gap1", 32'(pop_cyc[2] - pop_cyc[1]), 3);

      // Four sources, bursts of four then remainders
      do_reset();
      for (int k = 0; k < 6; k++) begin
         for (int s = 0; s < N_SRC; s++) push(s, 8'((s << 4) | k));
      end
      wait_log("t2_words", 24, 300);
      repeat (10) tick();
      chk("t2_count", 32'(src_log.size()), 24);
      for (int i = 0; i < 24; i++) chk("t2_order", 32'(src_log[i]), 32'(exp_order[i]));

      // Output stall
      src_log.delete();
      dat_log.delete();
      m_ready = 1'b0;
      push(1, 8'hA5);
      wait_valid("t3_valid", 20);
      n0 = pop_cyc.size();
      repeat (10) tick();
      chk("t3_no_rd_en", 32'(pop_cyc.size()), 32'(n0));
      chk("t3_valid_hold", 32'(m_valid), 1);
      chk("t3_data", 32'(m_data), 32'hA5);
      chk("t3_src", 32'(m_src), 1);
      m_ready = 1'b1;
      wait_log("t3_done", 1, 10);

      // arb_en dropped during S_POP
      src_log.delete();
      n0 = pop_cyc.size();
      push(3, 8'h31);
      push(3, 8'h32);
      for (int i = 0; i < 20 && fifo_rd_en == '0; i++) tick();
      chk("t4_pop_seen", 32'(fifo_rd_en), 32'h8);
      arb_en = 1'b0;
      repeat (10) tick();
      chk("t4_delivered", 32'(src_log.size()), 1);
      chk("t4_busy", 32'(busy), 0);
      chk("t4_pops", 32'(pop_cyc.size()), 32'(n0 + 1));
      chk("t4_left", 32'(fq[3].size()), 1);
      arb_en = 1'b1;
      wait_log("t4_resume", 2, 20);
      chk("t4_src", 32'(src_log[1]), 3);

      // Reset while holding a word in S_OUT
      src_log.delete();
      push(2, 8'h41);
      wait_log("t5_pre", 1, 20);
      m_ready = 1'b0;
      push(2, 8'h42);
      push(2, 8'h43);
      wait_valid("t5_valid", 20);
      repeat (2) tick();
      chk("t5_busy_pre", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_valid", 32'(m_valid), 0);
      chk("t5_async_busy", 32'(busy), 0);
      chk("t5_async_rd_en", 32'(fifo_rd_en), 0);
      clear_all();
      repeat (2) tick();
      rst_n = 1'b1;
      m_ready = 1'b1;
      push(0, 8'h01);
      push(3, 8'h03);
      wait_log("t5_restart", 2, 30);
      chk("t5_first_src", 32'(src_log[0]), 0);
      chk("t5_second_src", 32'(src_log[1]), 3);

      // Random fill and back-pressure
      pushed = 0;
      delivered = 0;
      for (int i = 0; i < 10000; i++) begin
         m_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0) begin
            int s;
            s = int'($urandom_range(0, N_SRC - 1));
            if (fq[s].size() < 8) push(s, 8'($urandom));
         end
         tick();
      end
      m_ready = 1'b1;
      for (int i = 0; i < 2000 && delivered < pushed; i++) tick();
      repeat (5) tick();
      chk("rand_delivered", 32'(delivered), 32'(pushed));
      for (int s = 0; s < N_SRC; s++) chk("rand_sb_left", 32'(exp_q[s].size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
